// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative radix-2 multiply/divide unit that owns HI/LO.
// One MULT/MULTU/DIV/DIVU is accepted in IDLE. It runs 32 RUN iterations on
// unsigned magnitudes, and FIX then applies the signs and writes HI/LO.
// MdStall holds execute while an operation is in flight and execute wants
// HI/LO or wants to start a new operation.
module muldiv_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            flush,
   input  logic            MdStart_EX,
   input  logic            MdOp_EX,
   input  logic            MdSigned_EX,
   input  logic [XLEN-1:0] SrcA_EX,
   input  logic [XLEN-1:0] SrcB_EX,
   input  logic            ReadHi_EX,
   input  logic            ReadLo_EX,
   input  logic            WriteHi_EX,
   input  logic            WriteLo_EX,
   output logic [XLEN-1:0] Hi,
   output logic [XLEN-1:0] Lo,
   output logic            MdBusy,
   output logic            MdStall,
   output logic            MdDone
);

   localparam int CNT_W = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;

   // Datapath registers. acc is the product high half or the remainder.
   // shreg is the multiplier, shifting out into the product low half, or
   // the dividend, shifting into the quotient. opnd is the multiplicand or
   // the divisor.
   logic [XLEN-1:0]   acc, shreg, opnd, orig_a;
   logic              div_op, res_neg, rem_neg;

   logic              start_go;
   logic              sign_a, sign_b;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_sh;
   logic              div_ge;
   logic [XLEN-1:0]   div_sub;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, hi_fix, lo_fix;

   // Magnitude of a two's complement value. The value is used raw when the
   // operation is unsigned.
   function automatic logic [XLEN-1:0] mag(input logic signed [XLEN-1:0] v, input logic sgn);
      if (sgn && v[XLEN-1])
         return -v;
      return v;
   endfunction

   function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v, input logic en);
      return en ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [2*XLEN-1:0] neg_2w(input logic [2*XLEN-1:0] v, input logic en);
      return en ? (~v + 1'b1) : v;
   endfunction

   assign start_go = (state == IDLE) && MdStart_EX;
   assign sign_a   = MdSigned_EX & SrcA_EX[XLEN-1];
   assign sign_b   = MdSigned_EX & SrcB_EX[XLEN-1];

   // Multiply step: add the multiplicand when the current multiplier bit is
   // set. The carry is kept so that it shifts into the top of acc.
   assign mul_sum = {1'b0, acc} + {1'b0, (shreg[0] ? opnd : '0)};

   // Restoring divide step. The shifted remainder needs one extra bit for
   // the compare. The difference always fits XLEN bits because rem < divisor.
   assign div_sh  = {acc, shreg[XLEN-1]};
   assign div_ge  = div_sh >= {1'b0, opnd};
   assign div_sub = div_sh[XLEN-1:0] - opnd;

   // Sign correction. A zero divisor overrides the datapath: the quotient
   // becomes all ones and the remainder becomes the original dividend.
   assign prod_fix = neg_2w({acc, shreg}, res_neg);
   assign quo_fix  = (opnd == '0) ? '1     : neg_w(shreg, res_neg);
   assign rem_fix  = (opnd == '0) ? orig_a : neg_w(acc, rem_neg);
   assign hi_fix   = div_op ? rem_fix : prod_fix[2*XLEN-1:XLEN];
   assign lo_fix   = div_op ? quo_fix : prod_fix[XLEN-1:0];

   // State register
   always_ff @(posedge clk or posedge flush) begin
      if (flush)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next state, busy and stall decode
   always_comb begin
      state_nxt = state;
      MdBusy    = (state != IDLE);
      MdStall   = MdBusy & (MdStart_EX | ReadHi_EX | ReadLo_EX | WriteHi_EX | WriteLo_EX);
      case (state)
         IDLE:    if (MdStart_EX) state_nxt = RUN;
         RUN:     if (cnt == CNT_W'(XLEN-1)) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Iteration counter, done pulse and architectural HI/LO
   always_ff @(posedge clk or posedge flush) begin
      if (flush) begin
         cnt    <= '0;
         MdDone <= 1'b0;
         Hi     <= '0;
         Lo     <= '0;
      end else begin
         MdDone <= (state == FIX);
         if (state == RUN)
            cnt <= cnt + 1'b1;
         else
            cnt <= '0;
         if (state == FIX) begin
            Hi <= hi_fix;
            Lo <= lo_fix;
         end else if (state == IDLE) begin
            if (WriteHi_EX) Hi <= SrcA_EX;
            if (WriteLo_EX) Lo <= SrcA_EX;
         end
      end
   end

   // Operand capture at start and one radix-2 iteration per RUN cycle
   always_ff @(posedge clk) begin
      if (start_go) begin
         acc     <= '0;
         shreg   <= MdOp_EX ? mag(SrcA_EX, MdSigned_EX) : mag(SrcB_EX, MdSigned_EX);
         opnd    <= MdOp_EX ? mag(SrcB_EX, MdSigned_EX) : mag(SrcA_EX, MdSigned_EX);
         orig_a  <= SrcA_EX;
         div_op  <= MdOp_EX;
         res_neg <= sign_a ^ sign_b;
         rem_neg <= sign_a;
      end else if (state == RUN) begin
         if (div_op) begin
            if (div_ge) begin
               acc   <= div_sub;
               shreg <= {shreg[XLEN-2:0], 1'b1};
            end else begin
               acc   <= div_sh[XLEN-1:0];
               shreg <= {shreg[XLEN-2:0], 1'b0};
            end
         end else begin
            acc   <= mul_sum[XLEN:1];
            shreg <= {mul_sum[0], shreg[XLEN-1:1]};
         end
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Testbench for muldiv_seq. Stimulus pushes the expected {HI,LO} into a
// queue, and a monitor pops and compares it on every MdDone pulse.
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        flush;
   logic        MdStart_EX, MdOp_EX, MdSigned_EX;
   logic [31:0] SrcA_EX, SrcB_EX;
   logic        ReadHi_EX, ReadLo_EX, WriteHi_EX, WriteLo_EX;
   logic [31:0] Hi, Lo;
   logic        MdBusy, MdStall, MdDone;

   int          total = 0;
   int          bad   = 0;
   logic [63:0] exp_q[$];
   logic [63:0] mon_exp;

   muldiv_seq #(.XLEN(32)) dut (
      .clk(clk), .flush(flush),
      .MdStart_EX(MdStart_EX), .MdOp_EX(MdOp_EX), .MdSigned_EX(MdSigned_EX),
      .SrcA_EX(SrcA_EX), .SrcB_EX(SrcB_EX),
      .ReadHi_EX(ReadHi_EX), .ReadLo_EX(ReadLo_EX),
      .WriteHi_EX(WriteHi_EX), .WriteLo_EX(WriteLo_EX),
      .Hi(Hi), .Lo(Lo), .MdBusy(MdBusy), .MdStall(MdStall), .MdDone(MdDone)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: {HI,LO} from plain 64-bit arithmetic.
   function automatic logic [63:0] model(input bit div, input bit sgn,
                                         input logic [31:0] a, input logic [31:0] b);
      longint sa, sbv, q, r;
      logic [31:0] uq, ur;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      if (!div) begin
         if (sgn) return 64'(sa * sbv);
         return {32'b0, a} * {32'b0, b};
      end
      if (b == 32'd0) return {a, 32'hFFFFFFFF};
      if (sgn) begin
         q = sa / sbv;
         r = sa % sbv;
         return {r[31:0], q[31:0]};
      end
      uq = a / b;
      ur = a % b;
      return {ur, uq};
   endfunction

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!flush && MdDone) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL done_unexpected: got done with hi=%h lo=%h, expected none", Hi, Lo);
         end else begin
            mon_exp = exp_q.pop_front();
            check("result_hilo", {Hi, Lo}, mon_exp);
         end
      end
   end

   task automatic idle_inputs();
      MdStart_EX = 0; MdOp_EX = 0; MdSigned_EX = 0;
      SrcA_EX = '0; SrcB_EX = '0;
      ReadHi_EX = 0; ReadLo_EX = 0; WriteHi_EX = 0; WriteLo_EX = 0;
   endtask

   task automatic drive_start(input bit div, input bit sgn, input logic [31:0] a, input logic [31:0] b);
      MdStart_EX = 1; MdOp_EX = div; MdSigned_EX = sgn;
      SrcA_EX = a; SrcB_EX = b;
   endtask

   // Count edges until MdDone is seen, starting just after the start edge.
   task automatic wait_done(output int lat);
      bit got;
      got = 0;
      lat = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (MdDone) begin
            got = 1;
            break;
         end
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL done_timeout: got no done after %0d cycles, expected done", lat);
      end
   endtask

   // Call before a rising edge while the DUT is idle. Returns at the
   // negedge of the done cycle.
   task automatic do_op(input bit div, input bit sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
      int lat;
      drive_start(div, sgn, a, b);
      #1;
      check("stall_idle", 64'(MdStall), 64'd0);
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      idle_inputs();
      check("busy_after_start", 64'(MdBusy), 64'd1);
      wait_done(lat);
      check("latency", 64'(lat), 64'd33);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, expected finish");
      $fatal(1);
   end

   initial begin
      int          stalls, lat;
      logic [31:0] a, b, a2, b2;
      bit          dv, sg;

      idle_inputs();
      flush     = 1;
      ReadLo_EX = 1;
      repeat (2) @(negedge clk);
      check("rst_hi", 64'(Hi), 64'd0);
      check("rst_lo", 64'(Lo), 64'd0);
      check("rst_busy", 64'(MdBusy), 64'd0);
      check("rst_stall", 64'(MdStall), 64'd0);
      check("rst_done", 64'(MdDone), 64'd0);
      flush     = 0;
      ReadLo_EX = 0;

      // Directed values; consecutive calls also exercise back-to-back starts.
      do_op(0, 1, 32'd7,        32'hFFFFFFFD, {32'hFFFFFFFF, 32'hFFFFFFEB});
      do_op(0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001});
      do_op(0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'h00000000, 32'h00000001});
      do_op(1, 1, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD});
      do_op(1, 0, 32'd100,      32'd7,        {32'd2,        32'd14});
      do_op(1, 1, 32'h12345678, 32'd0,        {32'h12345678, 32'hFFFFFFFF});
      do_op(1, 1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000});

      // A read in the done cycle is not stalled and sees the new LO.
      ReadLo_EX = 1;
      #1;
      check("read_after_done_stall", 64'(MdStall), 64'd0);
      check("read_after_done_lo", 64'(Lo), 64'h80000000);
      ReadLo_EX = 0;

      // Hold a read and a second start through a multiply.
      a  = $urandom;  b  = $urandom;
      a2 = $urandom;  b2 = $urandom_range(1, 1000);
      drive_start(0, 1, a, b);
      exp_q.push_back(model(0, 1, a, b));
      @(posedge clk);
      #1;
      drive_start(1, 0, a2, b2);
      ReadLo_EX = 1;
      check("stall_busy", 64'(MdBusy), 64'd1);
      stalls = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (MdStall) stalls++;
         else break;
      end
      check("stall_cycles", 64'(stalls), 64'd33);
      check("stall_drop_in_done", 64'(MdDone), 64'd1);
      exp_q.push_back(model(1, 0, a2, b2));
      @(posedge clk);
      #1;
      idle_inputs();
      check("held_start_busy", 64'(MdBusy), 64'd1);
      wait_done(lat);
      check("held_start_latency", 64'(lat), 64'd33);

      // MTHI together with a start: HI takes SrcA now, FIX overwrites it later.
      a = $urandom; b = $urandom;
      drive_start(0, 0, a, b);
      WriteHi_EX = 1;
      exp_q.push_back(model(0, 0, a, b));
      @(posedge clk);
      #1;
      idle_inputs();
      check("write_with_start_hi", 64'(Hi), 64'(a));
      wait_done(lat);

      // Random operations checked against the model.
      for (int n = 0; n < 24; n++) begin
         dv = 1'($urandom);
         sg = 1'($urandom);
         a  = $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 15);
            2:       b = 32'hFFFFFFFF;
            3:       begin a = 32'h80000000; b = $urandom; end
            default: b = $urandom;
         endcase
         do_op(dv, sg, a, b, model(dv, sg, a, b));
      end

      // MTHI/MTLO in IDLE, then a divide aborted by flush.
      WriteHi_EX = 1; WriteLo_EX = 1; SrcA_EX = 32'hA5A5A5A5;
      @(posedge clk);
      #1;
      idle_inputs();
      check("mthi_mtlo", {Hi, Lo}, {32'hA5A5A5A5, 32'hA5A5A5A5});
      drive_start(1, 1, $urandom, $urandom_range(1, 99));
      @(posedge clk);
      #1;
      idle_inputs();
      repeat (9) @(posedge clk);
      #1;
      flush = 1;
      #1;
      check("flush_busy", 64'(MdBusy), 64'd0);
      check("flush_hilo", {Hi, Lo}, 64'd0);
      @(negedge clk);
      flush = 0;
      WriteHi_EX = 1; SrcA_EX = 32'hDEADBEEF;
      @(posedge clk);
      #1;
      idle_inputs();
      check("mthi_after_flush", {Hi, Lo}, {32'hDEADBEEF, 32'h0});
      repeat (40) @(posedge clk);
      @(negedge clk);
      check("no_pending_results", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer that owns the HI/LO register pair for the pipelined MIPS core. It sits beside the execute stage, accepts one MULT/MULTU/DIV/DIVU per operation, runs a 32-iteration radix-2 datapath, and holds off the pipeline through a stall output whenever execute touches HI/LO or issues a new operation while one is in flight. The stall output is OR'ed into the core's global `AnyStall`.

## Interface
Parameters:
- `XLEN`, 32: operand and HI/LO width. Only 32 is supported; the iteration counter is log2(XLEN) bits.

Ports:
- `clk`  input  1  core clock; all state updates on rising edge.
- `flush`  input  1  asynchronous, active-high reset.
- `MdStart_EX`  input  1  request to start an operation using `SrcA_EX` and `SrcB_EX`.
- `MdOp_EX`  input  1  0 = multiply, 1 = divide.
- `MdSigned_EX`  input  1  1 = signed (MULT/DIV), 0 = unsigned (MULTU/DIVU).
- `SrcA_EX`  input  32  multiplicand / dividend.
- `SrcB_EX`  input  32  multiplier / divisor.
- `ReadHi_EX`, `ReadLo_EX`  input  1 each  MFHI / MFLO in execute.
- `WriteHi_EX`, `WriteLo_EX`  input  1 each  MTHI / MTLO in execute; data on `SrcA_EX`.
- `Hi`, `Lo`  output  32 each  architectural HI/LO registers.
- `MdBusy`  output  1  operation in flight.
- `MdStall`  output  1  execute must hold; combinational.
- `MdDone`  output  1  one-cycle pulse after HI/LO are written by a completed operation.

## Operation
- States: IDLE, RUN, FIX. `MdBusy` = (state != IDLE).
- IDLE: on `MdStart_EX` at a rising edge, latch magnitudes |A|, |B| (absolute values only when `MdSigned_EX`=1; otherwise raw), result sign bits, op, and the original signed A. Clear 5-bit counter and the accumulator, then go to RUN.
- RUN, multiply: 64-bit {acc, mplier}. Each cycle, if mplier[0], add mcand to acc with a 33-bit carry. Then shift {carry, acc, mplier} right by 1.
- RUN, divide (restoring): shift {rem, quot} left by 1. If rem >= divisor, rem -= divisor and quot[0] = 1.
- RUN: the counter increments every cycle. At counter == 31 the state goes to FIX.
- FIX, multiply: if signed and signA ^ signB, negate the 64-bit product. HI = [63:32], LO = [31:0].
- FIX, divide: LO = quotient, negated if signed and signA ^ signB. HI = remainder, negated if signed and signA.
- Divide by zero: LO = 0xFFFFFFFF, HI = original A (the datapath result is overridden in FIX).
- Signed 0x80000000 / -1: LO = 0x80000000, HI = 0. This falls out naturally from the unsigned-magnitude path; it must not trap.
- FIX always transitions to IDLE and asserts `MdDone` for the following cycle.
- `MdStall` = `MdBusy` & (`MdStart_EX` | `ReadHi_EX` | `ReadLo_EX` | `WriteHi_EX` | `WriteLo_EX`).
- Requests arriving while busy are not consumed. The stalled pipeline re-presents them, and they are acted on in the first IDLE cycle.
- IDLE write: `WriteHi_EX` / `WriteLo_EX` load `SrcA_EX` into HI/LO at the edge. If a start is asserted in the same cycle, the start still launches, and its FIX result later overwrites HI/LO.
- IDLE read: same-cycle start with a read returns the pre-operation HI/LO, since the outputs are registered.

## Timing
- Reset values: `Hi` = 0, `Lo` = 0, `MdBusy` = 0, `MdStall` = 0, `MdDone` = 0. State = IDLE, counter = 0.
- `flush` mid-operation aborts immediately, and HI/LO return to 0.
- Let the start be sampled at edge E0.
  - RUN iterations occur at edges E1..E32.
  - FIX writes HI/LO at E33.
  - `MdBusy` is high from after E0 until E33: 33 cycles.
  - `MdDone` is high for the single cycle after E33.
- Back-to-back operations: the earliest next start is sampled at E33 + 1 edge. In the cycle after E33, state is IDLE and the start is accepted.
- A read issued in the cycle after E33 is not stalled and sees the new HI/LO.
- `MdStall` has no registered delay. It is valid in the same cycle as the request and is low in every IDLE cycle.

## Test plan
- Signed MULT A = 7, B = 0xFFFFFFFD (-3) -> `MdDone` in the cycle after E33; HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- MULTU A = B = 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001. Repeat as signed MULT -> HI = 0, LO = 1.
- Signed DIV A = 0xFFFFFFF9 (-7), B = 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU A = 100, B = 7 -> LO = 14, HI = 2.
- DIV with B = 0, A = 0x12345678 -> LO = 0xFFFFFFFF, HI = 0x12345678. Signed 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- Start MULT, then hold `ReadLo_EX` = 1 from the next cycle -> `MdStall` = 1 for exactly 33 cycles, dropping in the `MdDone` cycle. A second start during busy is ignored, and the held start launches in the first IDLE cycle.
- Start DIV, assert `flush` at cycle 10 -> `MdBusy`, HI, LO = 0 immediately. After release, MTHI 0xDEADBEEF in IDLE -> HI = 0xDEADBEEF on the next edge.
